// File: rtl/bullet_hit_detect_pkg.sv
// Shared types and default geometry/timing constants for the bullet/enemy
// collision block and its score counter.
package bullet_hit_detect_pkg;

  // Enemy life cycle as seen by the collision logic.
  typedef enum logic [1:0] {
    ALIVE    = 2'd0,
    HIT_HOLD = 2'd1,
    EXPLODE  = 2'd2,
    RESPAWN  = 2'd3
  } hit_state_e;

  // Sprite geometry, pixels. The bullet lives in a space offset by Y_OFF.
  localparam int BW_DEF       = 10;
  localparam int BH_DEF       = 40;
  localparam int EW_DEF       = 48;
  localparam int EH_DEF       = 32;
  localparam int Y_OFF_DEF    = 480;

  // Sequencing: collide hold limit in clk cycles, timers in tick pulses.
  localparam int HOLD_MAX_DEF = 64;
  localparam int EXPL_T_DEF   = 30;
  localparam int RESP_T_DEF   = 60;

  // Score display width in BCD digits.
  localparam int SCORE_DIGITS = 4;

  // Larger of two integers, used to size the shared explode/respawn timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bullet_hit_detect_score_bcd4.sv
// Four-digit BCD hit counter. Each inc adds one; the count sticks at 9999.
module score_bcd4
  import bullet_hit_detect_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] score_bcd
);

  logic [3:0]            digit_q [SCORE_DIGITS];
  logic [3:0]            digit_d [SCORE_DIGITS];
  // nine_run[k] is set when every digit below position k reads 9.
  logic [SCORE_DIGITS:0] nine_run;
  logic [SCORE_DIGITS-1:0] carry;
  logic                  saturated;

  assign nine_run[0] = 1'b1;
  // All four digits at 9 means 9999: further increments are dropped.
  assign saturated   = nine_run[SCORE_DIGITS];

  for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_digit
    assign nine_run[gi+1] = nine_run[gi] & (digit_q[gi] == 4'd9);
    // A digit steps when the increment ripples up to it.
    assign carry[gi]      = inc & ~saturated & nine_run[gi];

    // Next value of one decimal digit: wrap 9 -> 0 when it steps.
    always_comb begin
      digit_d[gi] = digit_q[gi];
      if (carry[gi]) begin
        digit_d[gi] = (digit_q[gi] == 4'd9) ? 4'd0 : digit_q[gi] + 4'd1;
      end
    end

    // Digit register.
    always_ff @(posedge clk) begin
      if (rst) begin
        digit_q[gi] <= 4'd0;
      end else begin
        digit_q[gi] <= digit_d[gi];
      end
    end

    assign score_bcd[gi*4 +: 4] = digit_q[gi];
  end

endmodule

// File: rtl/bullet_hit_detect.sv
// Bullet vs. single enemy collision: overlap test, hit/explode/respawn
// sequencing, active-low collide handshake back to the bullet stage, and
// a saturating BCD score.
module bullet_hit_detect
  import bullet_hit_detect_pkg::*;
#(
  parameter int BW       = BW_DEF,
  parameter int BH       = BH_DEF,
  parameter int EW       = EW_DEF,
  parameter int EH       = EH_DEF,
  parameter int Y_OFF    = Y_OFF_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int EXPL_T   = EXPL_T_DEF,
  parameter int RESP_T   = RESP_T_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic        mybullet_exist,
  input  logic [9:0]  e_x,
  input  logic [9:0]  e_y,
  output logic        collide,
  output logic        hit_pulse,
  output logic        enemy_alive,
  output logic        enemy_explode,
  output logic [15:0] score_bcd
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(max_int(EXPL_T, RESP_T) + 1);

  localparam logic [10:0]   BW11     = 11'(BW);
  localparam logic [10:0]   BH11     = 11'(BH);
  localparam logic [10:0]   EW11     = 11'(EW);
  localparam logic [10:0]   EH11     = 11'(EH);
  localparam logic [10:0]   YOFF11   = 11'(Y_OFF);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_MAX - 1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] TMR_EXPL = TW'(EXPL_T);
  localparam logic [TW-1:0] TMR_RESP = TW'(RESP_T);

  hit_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          collide_q, collide_d;
  logic          hit_pulse_q, hit_pulse_d;
  logic          alive_q, alive_d;
  logic          explode_q, explode_d;
  logic          score_inc;

  // Overlap is evaluated in 11 bits so the enemy box shifted into bullet
  // space (e_y + Y_OFF + EH) never wraps.
  logic [10:0] bx11, by11, ex11, ey11;
  logic        ov;
  logic        hit_cond;

  assign bx11 = {1'b0, b_x};
  assign by11 = {1'b0, b_y};
  assign ex11 = {1'b0, e_x};
  assign ey11 = {1'b0, e_y};

  assign ov = (bx11 < ex11 + EW11) &
              (bx11 + BW11 > ex11) &
              (by11 < ey11 + YOFF11 + EH11) &
              (by11 + BH11 > ey11 + YOFF11);

  // A bullet above the offset line is off screen and cannot hit.
  assign hit_cond = ov & mybullet_exist & (by11 > YOFF11);

  // Next-state and registered-output logic for the enemy life cycle.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    tmr_d       = tmr_q;
    collide_d   = 1'b1;
    hit_pulse_d = 1'b0;
    alive_d     = alive_q;
    explode_d   = explode_q;
    score_inc   = 1'b0;

    unique case (state_q)
      ALIVE: begin
        // Timers are idle here, so a coincident tick has nothing to do.
        if (hit_cond) begin
          state_d     = HIT_HOLD;
          collide_d   = 1'b0;
          hit_pulse_d = 1'b1;
          hold_cnt_d  = '0;
          score_inc   = 1'b1;
        end
      end

      HIT_HOLD: begin
        // Keep collide low until the bullet stage retires the bullet, but
        // never longer than HOLD_MAX cycles in case it never does.
        collide_d  = 1'b0;
        hold_cnt_d = hold_cnt_q + HOLD_ONE;
        if (!mybullet_exist || (hold_cnt_q == HOLD_END)) begin
          state_d   = EXPLODE;
          collide_d = 1'b1;
          alive_d   = 1'b0;
          explode_d = 1'b1;
          tmr_d     = TMR_EXPL;
        end
      end

      EXPLODE: begin
        if (tick) begin
          tmr_d = tmr_q - TMR_ONE;
          if (tmr_q == TMR_ONE) begin
            state_d   = RESPAWN;
            explode_d = 1'b0;
            tmr_d     = TMR_RESP;
          end
        end
      end

      RESPAWN: begin
        if (tick) begin
          tmr_d = tmr_q - TMR_ONE;
          if (tmr_q == TMR_ONE) begin
            state_d = ALIVE;
            alive_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ALIVE;
        alive_d = 1'b1;
      end
    endcase
  end

  // State, counters and output registers; reset overrides every event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ALIVE;
      hold_cnt_q  <= '0;
      tmr_q       <= '0;
      collide_q   <= 1'b1;
      hit_pulse_q <= 1'b0;
      alive_q     <= 1'b1;
      explode_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      tmr_q       <= tmr_d;
      collide_q   <= collide_d;
      hit_pulse_q <= hit_pulse_d;
      alive_q     <= alive_d;
      explode_q   <= explode_d;
    end
  end

  assign collide       = collide_q;
  assign hit_pulse     = hit_pulse_q;
  assign enemy_alive   = alive_q;
  assign enemy_explode = explode_q;

  score_bcd4 u_score (
    .clk      (clk),
    .rst      (rst),
    .inc      (score_inc),
    .score_bcd(score_bcd)
  );

endmodule

// File: tb/tb_bullet_hit_detect.sv
// Self-checking bench for bullet_hit_detect: table of single-hit overlap
// vectors, directed multi-cycle sequences, randomized traffic against a
// behavioural model, and a fast-timer instance for score saturation.
module tb_bullet_hit_detect;

  localparam int BW = 10, BH = 40, EW = 48, EH = 32, YO = 480;
  localparam int HOLD_MAX = 64, EXPL_T = 30, RESP_T = 60;

  logic        clk = 1'b0;
  logic        rst, tick, exist;
  logic [9:0]  b_x, b_y, e_x, e_y;
  logic        collide, hit_pulse, enemy_alive, enemy_explode;
  logic [15:0] score_bcd;

  // Saturation instance: 4-cycle hit loop so 10000 hits stay affordable.
  logic        rst_s;
  logic        collide_s, hit_pulse_s, alive_s, explode_s;
  logic [15:0] score_s;

  always #5 clk = ~clk;

  bullet_hit_detect dut (
    .clk(clk), .rst(rst), .tick(tick),
    .b_x(b_x), .b_y(b_y), .mybullet_exist(exist), .e_x(e_x), .e_y(e_y),
    .collide(collide), .hit_pulse(hit_pulse), .enemy_alive(enemy_alive),
    .enemy_explode(enemy_explode), .score_bcd(score_bcd)
  );

  bullet_hit_detect #(.HOLD_MAX(1), .EXPL_T(1), .RESP_T(1)) dut_sat (
    .clk(clk), .rst(rst_s), .tick(1'b1),
    .b_x(10'd100), .b_y(10'd700), .mybullet_exist(1'b1),
    .e_x(10'd90), .e_y(10'd200),
    .collide(collide_s), .hit_pulse(hit_pulse_s), .enemy_alive(alive_s),
    .enemy_explode(explode_s), .score_bcd(score_s)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // phase: 0 alive, 1 collide held, 2 exploding, 3 waiting to respawn
  int m_phase, m_hold, m_tmr, m_score;
  bit m_pulse;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic bit would_hit(input int bx, input int by, input int ex,
                                   input int ey, input bit ex_live);
    bit ovl;
    ovl = (bx < ex + EW) && (bx + BW > ex) && (by < ey + YO + EH) && (by + BH > ey + YO);
    return ovl && ex_live && (by > YO);
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_hold = 0; m_tmr = 0; m_score = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      case (m_phase)
        0: if (would_hit(int'(b_x), int'(b_y), int'(e_x), int'(e_y), exist)) begin
             m_phase = 1; m_pulse = 1; m_hold = 0;
             if (m_score < 9999) m_score++;
           end
        1: begin
             m_hold++;
             if (!exist || m_hold == HOLD_MAX) begin m_phase = 2; m_tmr = EXPL_T; end
           end
        2: if (tick) begin
             m_tmr--;
             if (m_tmr == 0) begin m_phase = 3; m_tmr = RESP_T; end
           end
        default: if (tick) begin
             m_tmr--;
             if (m_tmr == 0) m_phase = 0;
           end
      endcase
    end
  endtask

  // One clock: step model, let the DUT take the edge, compare on negedge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("seq_collide",  collide,       (m_phase != 1));
    chk("seq_pulse",    hit_pulse,     m_pulse);
    chk("seq_alive",    enemy_alive,   (m_phase <= 1));
    chk("seq_explode",  enemy_explode, (m_phase == 2));
    chk("seq_score",    score_bcd,     to_bcd(m_score));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; exist = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_pos(input int bx, input int by, input int ex, input int ey, input bit ev);
    b_x = 10'(bx); b_y = 10'(by); e_x = 10'(ex); e_y = 10'(ey); exist = ev;
  endtask

  typedef struct {
    int          bx, by, ex, ey;
    bit          ev;
    bit          exp_hit;
    logic [15:0] exp_score;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int low_cnt, pulses, bad, cyc;
    rst = 1'b1; rst_s = 1'b1; tick = 1'b0;
    set_pos(0, 0, 300, 0, 1'b0);

    vecs[0] = '{100, 700,  90, 200, 1'b1, 1'b1, 16'h0001}; // nominal hit
    vecs[1] = '{100, 480,  90,   0, 1'b1, 1'b0, 16'h0000}; // overlap but b_y == Y_OFF
    vecs[2] = '{138, 700,  90, 200, 1'b1, 1'b0, 16'h0000}; // b_x == e_x + EW
    vecs[3] = '{137, 700,  90, 200, 1'b1, 1'b1, 16'h0001}; // last column inside
    vecs[4] = '{100, 700,  90, 200, 1'b0, 1'b0, 16'h0000}; // bullet retired
    vecs[5] = '{ 80, 700,  90, 200, 1'b1, 1'b0, 16'h0000}; // b_x + BW == e_x
    vecs[6] = '{ 81, 700,  90, 200, 1'b1, 1'b1, 16'h0001}; // first column inside
    vecs[7] = '{100, 712,  90, 200, 1'b1, 1'b0, 16'h0000}; // b_y == e_y+Y_OFF+EH
    vecs[8] = '{100, 711,  90, 200, 1'b1, 1'b1, 16'h0001}; // last row inside
    vecs[9] = '{100, 640,  90, 200, 1'b1, 1'b0, 16'h0000}; // b_y+BH == e_y+Y_OFF

    // Reset state.
    do_reset();
    chk("rst_collide", collide, 1'b1);
    chk("rst_pulse",   hit_pulse, 1'b0);
    chk("rst_alive",   enemy_alive, 1'b1);
    chk("rst_explode", enemy_explode, 1'b0);
    chk("rst_score",   score_bcd, 16'h0000);

    // Table: one edge per vector from a fresh reset.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      set_pos(vecs[i].bx, vecs[i].by, vecs[i].ex, vecs[i].ey, vecs[i].ev);
      cycle();
      $display("vec %0d: b=(%0d,%0d) e=(%0d,%0d) exist=%0b -> pulse=%0b collide=%0b score=%h",
               i, vecs[i].bx, vecs[i].by, vecs[i].ex, vecs[i].ey, vecs[i].ev,
               hit_pulse, collide, score_bcd);
      chk($sformatf("vec%0d_pulse", i),   hit_pulse, vecs[i].exp_hit);
      chk($sformatf("vec%0d_collide", i), collide,   !vecs[i].exp_hit);
      chk($sformatf("vec%0d_score", i),   score_bcd, vecs[i].exp_score);
    end

    // Hit, hold 3 cycles, retire, then explode/respawn timing.
    do_reset();
    set_pos(100, 700, 90, 200, 1'b1);
    cycle();
    repeat (3) cycle();
    chk("hold_collide_low", collide, 1'b0);
    chk("hold_no_pulse", hit_pulse, 1'b0);
    exist = 1'b0;
    cycle();
    chk("exit_collide", collide, 1'b1);
    chk("exit_alive", enemy_alive, 1'b0);
    chk("exit_explode", enemy_explode, 1'b1);
    exist = 1'b1; // overlapping bullet while exploding must be ignored
    for (int k = 1; k <= EXPL_T; k++) begin
      tick = 1'b1; cycle();
      tick = 1'b0; cycle();
      if (k == EXPL_T - 1) chk("expl_before_end", enemy_explode, 1'b1);
    end
    chk("expl_done", enemy_explode, 1'b0);
    chk("expl_done_alive", enemy_alive, 1'b0);
    chk("expl_score_kept", score_bcd, 16'h0001);
    exist = 1'b0;
    for (int k = 1; k <= RESP_T; k++) begin
      tick = 1'b1; cycle();
      tick = 1'b0;
      if (k == RESP_T - 1) chk("resp_before_end", enemy_alive, 1'b0);
    end
    chk("resp_done", enemy_alive, 1'b1);
    $display("seq retire: score=%h alive=%0b", score_bcd, enemy_alive);

    // Bullet never retires: collide held low for HOLD_MAX cycles.
    do_reset();
    set_pos(100, 700, 90, 200, 1'b1);
    low_cnt = 0;
    cycle();
    if (collide == 1'b0) low_cnt++;
    for (int k = 0; k < 200 && collide == 1'b0; k++) begin
      cycle();
      if (collide == 1'b0) low_cnt++;
    end
    $display("seq hold_max: collide low %0d cycles", low_cnt);
    chk("hold_max_len", low_cnt, HOLD_MAX);
    chk("hold_max_explode", enemy_explode, 1'b1);

    // Reset during explosion.
    do_reset();
    set_pos(100, 700, 90, 200, 1'b1);
    cycle();
    exist = 1'b0;
    cycle();
    tick = 1'b1; cycle(); tick = 1'b0;
    chk("mid_explode", enemy_explode, 1'b1);
    rst = 1'b1; cycle(); rst = 1'b0;
    $display("seq mid reset: alive=%0b explode=%0b score=%h", enemy_alive, enemy_explode, score_bcd);
    chk("mid_rst_alive", enemy_alive, 1'b1);
    chk("mid_rst_explode", enemy_explode, 1'b0);
    chk("mid_rst_score", score_bcd, 16'h0000);
    chk("mid_rst_collide", collide, 1'b1);

    // Randomized traffic around the enemy box against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      int ex, ey;
      ex = $urandom_range(80, 100);
      ey = $urandom_range(0, 60);
      set_pos($urandom_range(ex - 15, ex + 55), $urandom_range(ey + YO - 50, ey + YO + 40),
              ex, ey, ($urandom_range(0, 9) < 8));
      tick = ($urandom_range(0, 1) == 1);
      rst  = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    $display("random: done, score=%h", score_bcd);

    // Saturation: count 10000 hits on the fast instance.
    rst_s = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_s = 1'b0;
    pulses = 0; bad = 0; cyc = 0;
    while (pulses < 10000 && cyc < 60000) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (hit_pulse_s) begin
        pulses++;
        if (score_s !== to_bcd((pulses > 9999) ? 9999 : pulses)) begin
          if (bad == 0) $display("sat: first bad score %h at hit %0d", score_s, pulses);
          bad++;
        end
      end
    end
    $display("sat: %0d hits in %0d cycles, score=%h, pulse=%0b", pulses, cyc, score_s, hit_pulse_s);
    chk("sat_hits_seen", pulses, 10000);
    chk("sat_seq_errors", bad, 0);
    chk("sat_score", score_s, 16'h9999);
    chk("sat_pulse", hit_pulse_s, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("sat_pulse_single", hit_pulse_s, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
